// File: rtl/shift_reg_usr_pkg.sv
// Shared definitions for the universal shift register: mode encodings
// and a small helper for the shift-frame counter.
package shift_reg_usr_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  // True for modes that move data serially and therefore advance the frame counter.
  function automatic logic is_shift(input mode_e m);
    return (m == MODE_SHR) || (m == MODE_SHL);
  endfunction

endpackage : shift_reg_usr_pkg

// File: rtl/shift_reg_usr_dff_r.sv
// Single D flip-flop with asynchronous active-low reset; the storage
// primitive for every state bit of the shift register.
module shift_reg_usr_dff_r (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  // NOTE: sequential state uses non-blocking assignment so all flops sample together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) q <= 1'b0;
    else          q <= d;
  end

endmodule : shift_reg_usr_dff_r

// File: rtl/shift_reg_usr.sv
// Universal shift register (hold / shift right / shift left / load) with
// a frame counter that pulses frame_done once per WIDTH consecutive shifts.
module shift_reg_usr
  import shift_reg_usr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CW    = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr_n,
  input  logic [1:0]       mode,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q,
  output logic             so_r,
  output logic             so_l,
  output logic [CW-1:0]    shift_cnt,
  output logic             frame_done
);

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  mode_e            mode_s;
  logic [WIDTH-1:0] reg_d, reg_q;
  logic [WIDTH-1:0] shr_src, shl_src;
  logic [CW-1:0]    cnt_d, cnt_q;
  logic             done_d, done_q;

  assign mode_s  = mode_e'(mode);
  assign shr_src = {sin_r, reg_q[WIDTH-1:1]};
  assign shl_src = {reg_q[WIDTH-2:0], sin_l};

  // Per-bit 4:1 next-state mux; clear gates the d inputs rather than the async reset.
  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    reg_d = reg_q;
    for (int i = 0; i < WIDTH; i++) begin
      unique case (mode_s)
        MODE_HOLD: reg_d[i] = reg_q[i];
        MODE_SHR:  reg_d[i] = shr_src[i];
        MODE_SHL:  reg_d[i] = shl_src[i];
        MODE_LOAD: reg_d[i] = d_in[i];
        default:   reg_d[i] = reg_q[i];
      endcase
    end
    if (!clr_n) reg_d = '0;
  end

  // Frame counter: direction changes keep counting, load/clear restart the frame.
  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (!clr_n || mode_s == MODE_LOAD) begin
      cnt_d = '0;
    end else if (is_shift(mode_s)) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_reg
    shift_reg_usr_dff_r u_dff (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (reg_d[gi]),
      .q       (reg_q[gi])
    );
  end

  for (genvar gc = 0; gc < CW; gc++) begin : g_cnt
    shift_reg_usr_dff_r u_dff (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (cnt_d[gc]),
      .q       (cnt_q[gc])
    );
  end

  shift_reg_usr_dff_r u_done (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (done_d),
    .q       (done_q)
  );

  assign q          = reg_q;
  assign so_r       = reg_q[0];
  assign so_l       = reg_q[WIDTH-1];
  assign shift_cnt  = cnt_q;
  assign frame_done = done_q;

endmodule : shift_reg_usr
